chase_led_ctrl: RTL

//  Sequencer for the chasing-LED display: owns the step-rate divider and a one-hot position register.

---
 rtl/chase_led_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/chase_led_ctrl.sv
// ---------------------------------------------------------------------------
// chase_led_ctrl
//
// Sequencer for the chasing-LED display. It owns the step-rate divider and a
// one-hot position register. It starts, pauses, stops and steers the chase.
// Stepping is driven by a single-cycle tick enable in the clk domain; no
// derived clock is generated.
//
// Configuration macro: CHASE_BOUNCE_EN
//   defined   -> the chase bounces at either end of the chain
//   undefined -> the chase wraps around (default build)
//
// Parameters
//   N_LEDS    number of LEDs in the chain (>=2)
//   BASE_DIV  clk cycles per step at speed=0 (>=2)
//   CNT_W     divider width; must hold (BASE_DIV<<3)-1
//
// Ports
//   clk    in   1       system clock
//   reset  in   1       synchronous, active-high reset
//   start  in   1       1-cycle pulse: (re)start the chase
//   stop   in   1       1-cycle pulse: end the chase, blank the LEDs
//   pause  in   1       level: freeze the chase while high
//   dir    in   1       0 = position increasing, 1 = decreasing (sampled on start)
//   speed  in   2       step period = BASE_DIV<<speed (sampled on start and each tick)
//   led    out  N_LEDS  one-hot LED drive, all-zero when idle
//   busy   out  1       high while running or paused
//   tick   out  1       1-cycle pulse coincident with each position step
// ---------------------------------------------------------------------------
module chase_led_ctrl #(
    parameter int N_LEDS   = 8,
    parameter int BASE_DIV = 312_500,
    parameter int CNT_W    = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              dir,
    input  logic [1:0]        speed,
    output logic [N_LEDS-1:0] led,
    output logic              busy,
    output logic              tick
);

    localparam int POS_W = $clog2(N_LEDS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(N_LEDS - 1);
    localparam logic [CNT_W-1:0] BASE_CNT   = CNT_W'(BASE_DIV);

    logic [1:0]        state_reg,   state_next;
    logic [POS_W-1:0]  pos_reg,     pos_next;
    logic              dir_q_reg,   dir_q_next;
    logic [1:0]        speed_q_reg, speed_q_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic [N_LEDS-1:0] led_reg,     led_next;
    logic              busy_reg,    busy_next;
    logic              tick_reg,    tick_next;

    logic [CNT_W-1:0]  term_cnt;
    logic [POS_W-1:0]  step_pos;
    logic              step_dir;
    logic [N_LEDS-1:0] pos_onehot;

    // Last count of the current interval; compared at the divider width.
    assign term_cnt = (BASE_CNT << speed_q_reg) - CNT_W'(1);

    // Position/direction after one step, including end-of-chain handling.
    always_comb begin
        step_pos = pos_reg;
        step_dir = dir_q_reg;
`ifdef CHASE_BOUNCE_EN
        // Turn around without repeating the end LED.
        if (!dir_q_reg) begin
            if (pos_reg == POS_LAST) begin
                step_dir = 1'b1;
                step_pos = POS_W'(N_LEDS - 2);
            end else begin
                step_pos = pos_reg + POS_W'(1);
            end
        end else begin
            if (pos_reg == '0) begin
                step_dir = 1'b0;
                step_pos = POS_W'(1);
            end else begin
                step_pos = pos_reg - POS_W'(1);
            end
        end
`else
        if (!dir_q_reg) begin
            step_pos = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);
        end else begin
            step_pos = (pos_reg == '0) ? POS_LAST : pos_reg - POS_W'(1);
        end
`endif
    end

    // Control: stop > start > pause; reset handled in the register block.
    always_comb begin
        state_next   = state_reg;
        pos_next     = pos_reg;
        dir_q_next   = dir_q_reg;
        speed_q_next = speed_q_reg;
        cnt_next     = cnt_reg;
        tick_next    = 1'b0;

        if (state_reg == ST_IDLE) begin
            // A stop in the same cycle cancels the start.
            if (start && !stop) begin
                state_next   = ST_RUN;
                dir_q_next   = dir;
                speed_q_next = speed;
                cnt_next     = '0;
                pos_next     = dir ? POS_LAST : '0;
            end
        end else if (state_reg == ST_RUN || state_reg == ST_PAUSE) begin
            if (stop) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end else if (start) begin
                state_next   = ST_RUN;
                dir_q_next   = dir;
                speed_q_next = speed;
                cnt_next     = '0;
                pos_next     = dir ? POS_LAST : '0;
            end else if (pause) begin
                // Counter holds so the remaining interval survives the pause.
                state_next = ST_PAUSE;
            end else begin
                // Running, or leaving pause: count in this same cycle so the
                // interval is stretched by exactly the paused cycles.
                state_next = ST_RUN;
                if (cnt_reg == term_cnt) begin
                    cnt_next     = '0;
                    tick_next    = 1'b1;
                    pos_next     = step_pos;
                    dir_q_next   = step_dir;
                    speed_q_next = speed;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
        end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end
    end

    // One-hot decode of the next position.
    generate
        for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_onehot
            assign pos_onehot[gi] = (pos_next == POS_W'(gi));
        end
    endgenerate

    assign busy_next = (state_next != ST_IDLE);
    assign led_next  = busy_next ? pos_onehot : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pos_reg     <= '0;
            dir_q_reg   <= 1'b0;
            speed_q_reg <= 2'd0;
            cnt_reg     <= '0;
            led_reg     <= '0;
            busy_reg    <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pos_reg     <= pos_next;
            dir_q_reg   <= dir_q_next;
            speed_q_reg <= speed_q_next;
            cnt_reg     <= cnt_next;
            led_reg     <= led_next;
            busy_reg    <= busy_next;
            tick_reg    <= tick_next;
        end
    end

    assign led  = led_reg;
    assign busy = busy_reg;
    assign tick = tick_reg;

endmodule
